val_op_sched: RTL and testbench

- Round-robin scheduler sharing one 8-bit value-transform unit among NREQ requesters.
- Each requester presents an operand and an opcode selecting one of the five transform functions of the value pipeline.
- Block arbitrates, computes, and returns a tagged result through a single response channel with valid/ready backpressure.
- Sits between the operand producers and the result consumer; only path into the transform datapath.

---
 rtl/val_op_sched.sv | 141 ++++++++++++++
 tb/tb_val_op_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/val_op_sched.sv
// Round-robin scheduler sharing one 8-bit value-transform unit among NREQ requesters.
// Define VAL_OP_SCHED_STATS_EN to add the stall_cnt / err_cnt statistics ports.
module val_op_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ*3-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [DW-1:0]     rsp_data,
    output logic              rsp_err
`ifdef VAL_OP_SCHED_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [7:0]        err_cnt
`endif
);

    localparam int unsigned OPW = 3;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr, rr_ptr_nxt;
    logic [IDW-1:0]  grant_id;
    logic            grant_found;
    logic            can_accept;
    logic            accept;
    int unsigned     idx;
    logic [DW-1:0]   sel_data;
    logic [OPW-1:0]  sel_op;
    logic [DW-1:0]   xform_data;
    logic            xform_err;
    logic [IDW-1:0]  rsp_id_nxt;
    logic [DW-1:0]   rsp_data_nxt;
    logic            rsp_err_nxt;

    // Search upward from rr_ptr with wrap for the first valid requester.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_found && req_valid[IDW'(idx)]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    assign can_accept = !rst && ((state == EMPTY) || rsp_ready);
    assign accept     = can_accept && grant_found;

    // Operand mux and one-hot ready for the granted requester.
    always_comb begin
        sel_data  = '0;
        sel_op    = '0;
        req_ready = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (IDW'(j) == grant_id) begin
                sel_data     = req_data[j*DW +: DW];
                sel_op       = req_op[j*OPW +: OPW];
                req_ready[j] = accept;
            end
        end
    end

    // Transform unit; all arithmetic wraps modulo 2^DW.
    always_comb begin
        xform_data = '0;
        xform_err  = 1'b0;
        case (sel_op)
            3'd0:    xform_data = sel_data + DW'(1);
            3'd1:    xform_data = sel_data + DW'(2);
            3'd2:    xform_data = sel_data + DW'(4);
            3'd3:    xform_data = DW'(sel_data << 2) + DW'(4);
            3'd4:    xform_data = DW'(sel_data << 3) + DW'(5);
            default: xform_err  = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        rsp_id_nxt   = rsp_id;
        rsp_data_nxt = rsp_data;
        rsp_err_nxt  = rsp_err;
        if (accept) begin
            state_nxt    = FULL;
            rr_ptr_nxt   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            rsp_id_nxt   = grant_id;
            rsp_data_nxt = xform_data;
            rsp_err_nxt  = xform_err;
        end else if (state == FULL && rsp_ready) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            rsp_valid <= (state_nxt == FULL);
            rsp_id    <= rsp_id_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

`ifdef VAL_OP_SCHED_STATS_EN
    // Saturating stall and illegal-opcode counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (rsp_valid && !rsp_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (accept && xform_err && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_val_op_sched.sv
// Self-checking bench for val_op_sched: opcode vector table, cycle model with
// response scoreboard, and directed round-robin / backpressure / reset sequences.
module tb_val_op_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [11:0] req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_err;
`ifdef VAL_OP_SCHED_STATS_EN
    logic [15:0] stall_cnt;
    logic [7:0]  err_cnt;
`endif

    val_op_sched #(.NREQ(4), .DW(8), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
`ifdef VAL_OP_SCHED_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       err;
    } rsp_t;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] op;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    int   n_cmp = 0;
    int   n_err = 0;
    rsp_t q[$];
    logic m_full = 1'b0;
    int   m_ptr  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t ref_xform(input logic [1:0] id, input logic [7:0] d, input logic [2:0] op);
        rsp_t r;
        r.id = id;
        r.err = 1'b0;
        case (op)
            3'd0: r.data = d + 8'd1;
            3'd1: r.data = d + 8'd2;
            3'd2: r.data = d + 8'd4;
            3'd3: r.data = 8'(d * 4) + 8'd4;
            3'd4: r.data = 8'(d * 8) + 8'd5;
            default: begin r.data = 8'h00; r.err = 1'b1; end
        endcase
        return r;
    endfunction

    // One clock cycle: drive, check combinational ready and held response, advance model.
    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic [11:0] op,
                        input logic rr, input logic r);
        logic can, found;
        int   g;
        logic [3:0] exp_rdy;
        req_valid = v; req_data = d; req_op = op; rsp_ready = rr; rst = r;
        #1;
        can = !r && (!m_full || rr);
        found = 1'b0;
        g = 0;
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (m_ptr + i) % 4;
            if (!found && v[k]) begin found = 1'b1; g = k; end
        end
        exp_rdy = (can && found) ? 4'(1 << g) : 4'b0000;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (m_full) begin
            if (q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL scoreboard: got response with empty queue at %0t", $time);
            end else begin
                chk("rsp_id",   32'(rsp_id),   32'(q[0].id));
                chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
                chk("rsp_err",  32'(rsp_err),  32'(q[0].err));
            end
        end
        if (r) begin
            m_full = 1'b0; m_ptr = 0; q.delete();
        end else begin
            if (m_full && rr) void'(q.pop_front());
            if (can && found) begin
                q.push_back(ref_xform(2'(g), d[g*8 +: 8], op[g*3 +: 3]));
                m_full = 1'b1;
                m_ptr = (g + 1) % 4;
            end else if (m_full && rr) begin
                m_full = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[12];
    logic [1:0] rr_ids[5];

    initial begin
        tbl[0]  = '{8'h10, 3'd3, 8'h44, 1'b0};
        tbl[1]  = '{8'hFF, 3'd0, 8'h00, 1'b0};
        tbl[2]  = '{8'hFE, 3'd1, 8'h00, 1'b0};
        tbl[3]  = '{8'h10, 3'd1, 8'h12, 1'b0};
        tbl[4]  = '{8'hFD, 3'd2, 8'h01, 1'b0};
        tbl[5]  = '{8'h40, 3'd4, 8'h05, 1'b0};
        tbl[6]  = '{8'h21, 3'd4, 8'h0D, 1'b0};
        tbl[7]  = '{8'h3F, 3'd3, 8'h00, 1'b0};
        tbl[8]  = '{8'h55, 3'd5, 8'h00, 1'b1};
        tbl[9]  = '{8'h12, 3'd6, 8'h00, 1'b1};
        tbl[10] = '{8'hAA, 3'd7, 8'h00, 1'b1};
        tbl[11] = '{8'h07, 3'd0, 8'h08, 1'b0};
        rr_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst = 1'b1; req_valid = '0; req_data = '0; req_op = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_id",    32'(rsp_id),    32'd0);
        chk("reset rsp_data",  32'(rsp_data),  32'd0);
        chk("reset rsp_err",   32'(rsp_err),   32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);

        // Opcode table, each vector from a different single requester.
        for (int i = 0; i < 12; i++) begin
            int k;
            logic [31:0] d;
            logic [11:0] op;
            k = i % 4;
            d = 32'h0; op = 12'h0;
            d[k*8 +: 8] = tbl[i].d;
            op[k*3 +: 3] = tbl[i].op;
            step(4'(1 << k), d, op, 1'b1, 1'b0);
            chk("tbl rsp_valid", 32'(rsp_valid), 32'd1);
            chk("tbl rsp_id",    32'(rsp_id),    32'(k));
            chk("tbl rsp_data",  32'(rsp_data),  32'(tbl[i].exp_data));
            chk("tbl rsp_err",   32'(rsp_err),   32'(tbl[i].exp_err));
        end
`ifdef VAL_OP_SCHED_STATS_EN
        chk("err_cnt", 32'(err_cnt), 32'd3);
`endif
        step(4'b0000, 32'h0, 12'h0, 1'b1, 1'b0);
        chk("drain rsp_valid", 32'(rsp_valid), 32'd0);

        // Round robin from a fresh pointer.
        step(4'b0000, 32'h0, 12'h0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 32'h03020100, 12'h000, 1'b1, 1'b0);
            chk("rr id", 32'(rsp_id), 32'(rr_ids[i]));
        end

        // Backpressure: held response, no grants, then back-to-back refill.
        for (int i = 0; i < 5; i++) step(4'b1111, 32'h44332211, 12'o4321, 1'b0, 1'b0);
        chk("bp held id", 32'(rsp_id), 32'd0);
        step(4'b1111, 32'h44332211, 12'o4321, 1'b1, 1'b0);
        chk("bp refill id", 32'(rsp_id), 32'd1);
        chk("bp refill valid", 32'(rsp_valid), 32'd1);

        // Reset while holding a stalled response.
        step(4'b1111, 32'h44332211, 12'o4321, 1'b0, 1'b0);
        step(4'b1111, 32'h44332211, 12'o4321, 1'b0, 1'b1);
        chk("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
        step(4'b1111, 32'h44332211, 12'o4321, 1'b1, 1'b0);
        chk("post reset id", 32'(rsp_id), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++)
            step(4'($urandom_range(0, 15)), $urandom, 12'($urandom), 1'($urandom_range(0, 1)), 1'b0);

`ifdef VAL_OP_SCHED_STATS_EN
        step(4'b0001, 32'h0, 12'h0, 1'b0, 1'b1);
        step(4'b0001, 32'h0, 12'h0, 1'b0, 1'b0);
        req_valid = 4'b0000;
        repeat (70000) @(posedge clk);
        #1;
        chk("stall_cnt sat", 32'(stall_cnt), 32'hFFFF);
        step(4'b0000, 32'h0, 12'h0, 1'b1, 1'b1);
        chk("stall_cnt reset", 32'(stall_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
